// File: rtl/carry_prop_pkg.sv
// Shared state type and bit-slicing helpers for the carry-resolution stream stage.
package carry_prop_pkg;

    typedef enum logic [1:0] {IDLE, PROC, RUN, FLUSH} cp_state_t;

    localparam int unsigned MAX_W     = 64;
    localparam int unsigned MAX_BUS_W = 1024;

    function automatic logic [MAX_W-1:0] ones(input int unsigned byte_w);
        return (byte_w >= MAX_W) ? '1 : ((MAX_W'(1) << byte_w) - MAX_W'(1));
    endfunction

    // Callers zero-extend the bus and truncate the result to their word width.
    function automatic logic [MAX_W-1:0] lane_slice(input logic [MAX_BUS_W-1:0] bus,
                                                    input int unsigned         lane,
                                                    input int unsigned         word_w);
        return MAX_W'(bus >> (lane * word_w)) & ones(word_w);
    endfunction

endpackage

// File: rtl/cp_out_reg.sv
// One-entry valid/ready holding register; loads only when empty or being drained.
module cp_out_reg #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         can_load
);

    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/carry_propagation_stream.sv
// Resolves late carries: keeps one pending byte plus a counted run of all-ones bytes
// and releases final bytes through a one-entry output register.
module carry_propagation_stream
    import carry_prop_pkg::*;
#(
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned N_IN   = 2,
    parameter int unsigned RUN_W  = 8
) (
    input  logic                         cp_clk,
    input  logic                         cp_reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(N_IN+1)-1:0]    in_count,
    input  logic [N_IN*(BYTE_W+1)-1:0]   in_bitstream,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BYTE_W-1:0]            out_byte,
    output logic                         out_last,
    output logic                         out_error
);

    localparam int unsigned WORD_W = BYTE_W + 1;
    localparam int unsigned CNT_W  = $clog2(N_IN + 1);
    localparam int unsigned K_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [BYTE_W-1:0] ONES  = BYTE_W'(ones(BYTE_W));
    localparam logic [RUN_W-1:0]  R_MAX = '1;

    cp_state_t                  state, state_n;
    logic [N_IN*WORD_W-1:0]     beat_bits;
    logic [CNT_W-1:0]           beat_count;
    logic                       beat_last;
    logic [K_W-1:0]             k, k_n;
    logic                       pv, pv_n;
    logic [BYTE_W-1:0]          p_byte, p_n;
    logic [RUN_W-1:0]           run_len, r_n;
    logic [RUN_W-1:0]           fill_cnt, fill_cnt_n;
    logic [BYTE_W-1:0]          fill_val, fill_val_n;
    logic                       err_q, err_set;
    logic                       latch, advance, last_lane;
    logic                       load, can_load;
    logic [WORD_W-1:0]          load_data, out_word;

    logic [WORD_W-1:0]          word;
    logic                       lane_c;
    logic [BYTE_W-1:0]          lane_l;
    logic                       lane_emit, lane_err;
    logic [BYTE_W-1:0]          lane_first, lane_fval, lane_p;
    logic [RUN_W-1:0]           lane_fill, lane_r;

    assign word      = WORD_W'(lane_slice(MAX_BUS_W'(beat_bits), 32'(k), WORD_W));
    assign lane_c    = word[BYTE_W];
    assign lane_l    = word[BYTE_W-1:0];
    assign last_lane = (32'(k) + 32'd1) >= 32'(beat_count);

    // Lane decode: first byte to emit, fill run that follows it, and the new P/R.
    always_comb begin
        lane_emit  = 1'b0;
        lane_err   = 1'b0;
        lane_first = p_byte;
        lane_fill  = '0;
        lane_fval  = '0;
        lane_p     = p_byte;
        lane_r     = run_len;
        if (!pv) begin
            lane_p   = lane_l;
            lane_r   = '0;
            lane_err = lane_c;
        end else if (!lane_c) begin
            if (lane_l == ONES) begin
                if (run_len == R_MAX) lane_err = 1'b1;
                else                  lane_r   = run_len + RUN_W'(1);
            end else begin
                lane_emit = 1'b1;
                lane_fill = run_len;
                lane_fval = ONES;
                lane_p    = lane_l;
                lane_r    = '0;
            end
        end else begin
            lane_err   = (p_byte == ONES);
            lane_first = p_byte + BYTE_W'(1);
            if (lane_l != ONES) begin
                lane_emit = 1'b1;
                lane_fill = run_len;
                lane_p    = lane_l;
                lane_r    = '0;
            end else if (run_len == '0) begin
                lane_p = p_byte + BYTE_W'(1);
                lane_r = RUN_W'(1);
            end else begin
                // Last zero of the carried run becomes the new pending byte.
                lane_emit = 1'b1;
                lane_fill = run_len - RUN_W'(1);
                lane_p    = '0;
                lane_r    = RUN_W'(1);
            end
        end
    end

    always_comb begin
        state_n    = state;
        k_n        = k;
        pv_n       = pv;
        p_n        = p_byte;
        r_n        = run_len;
        fill_cnt_n = fill_cnt;
        fill_val_n = fill_val;
        err_set    = 1'b0;
        latch      = 1'b0;
        advance    = 1'b0;
        load       = 1'b0;
        load_data  = '0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    latch = 1'b1;
                    k_n   = '0;
                    if (in_count == '0) state_n = in_last ? FLUSH : IDLE;
                    else                state_n = PROC;
                end
            end
            PROC: begin
                if (!lane_emit || can_load) begin
                    pv_n    = 1'b1;
                    p_n     = lane_p;
                    r_n     = lane_r;
                    err_set = lane_err;
                    if (lane_emit) begin
                        load       = 1'b1;
                        load_data  = {1'b0, lane_first};
                        fill_cnt_n = lane_fill;
                        fill_val_n = lane_fval;
                    end
                    if (lane_emit && lane_fill != '0) state_n = RUN;
                    else                               advance = 1'b1;
                end
            end
            RUN: begin
                if (can_load) begin
                    load       = 1'b1;
                    load_data  = {1'b0, fill_val};
                    fill_cnt_n = fill_cnt - RUN_W'(1);
                    if (fill_cnt == RUN_W'(1)) advance = 1'b1;
                end
            end
            FLUSH: begin
                if (pv) begin
                    if (can_load) begin
                        load       = 1'b1;
                        load_data  = {run_len == '0, p_byte};
                        pv_n       = 1'b0;
                        p_n        = '0;
                        r_n        = '0;
                        fill_cnt_n = run_len;
                        if (run_len == '0) state_n = IDLE;
                    end
                end else if (fill_cnt != '0) begin
                    if (can_load) begin
                        load       = 1'b1;
                        load_data  = {fill_cnt == RUN_W'(1), ONES};
                        fill_cnt_n = fill_cnt - RUN_W'(1);
                        if (fill_cnt == RUN_W'(1)) state_n = IDLE;
                    end
                end else begin
                    p_n     = '0;
                    r_n     = '0;
                    state_n = IDLE;
                end
            end
        endcase
        if (advance) begin
            if (last_lane) begin
                state_n = beat_last ? FLUSH : IDLE;
            end else begin
                k_n     = k + K_W'(1);
                state_n = PROC;
            end
        end
    end

    always_ff @(posedge cp_clk) begin
        if (cp_reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            beat_bits  <= '0;
            beat_count <= '0;
            beat_last  <= 1'b0;
            k          <= '0;
            pv         <= 1'b0;
            p_byte     <= '0;
            run_len    <= '0;
            fill_cnt   <= '0;
            fill_val   <= '0;
            err_q      <= 1'b0;
            out_error  <= 1'b0;
        end else begin
            state    <= state_n;
            in_ready <= (state_n == IDLE);
            k        <= k_n;
            pv       <= pv_n;
            p_byte   <= p_n;
            run_len  <= r_n;
            fill_cnt <= fill_cnt_n;
            fill_val <= fill_val_n;
            err_q    <= err_q | err_set;
            // Error flag only moves when the output register is not stalled.
            if (can_load) out_error <= err_q | err_set;
            if (latch) begin
                beat_bits  <= in_bitstream;
                beat_count <= in_count;
                beat_last  <= in_last;
            end
        end
    end

    cp_out_reg #(.W(WORD_W)) u_out_reg (
        .clk       (cp_clk),
        .reset     (cp_reset),
        .load      (load),
        .load_data (load_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_word),
        .can_load  (can_load)
    );

    assign out_last = out_word[BYTE_W];
    assign out_byte = out_word[BYTE_W-1:0];

endmodule

// File: tb/tb_carry_propagation_stream.sv
// Scoreboard bench: frames are resolved by a byte-list carry model, expected bytes
// are queued before stimulus, and a monitor pops them as the DUT hands bytes out.
module tb_carry_propagation_stream;

    logic        cp_clk = 1'b0;
    logic        cp_reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_count = '0;
    logic [17:0] in_bitstream = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        out_error;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mb[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         ready_mode = 1;
    int         n_beats = 0;

    always #5 cp_clk = ~cp_clk;

    carry_propagation_stream #(.BYTE_W(8), .N_IN(2), .RUN_W(8)) dut (
        .cp_clk       (cp_clk),
        .cp_reset     (cp_reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_count     (in_count),
        .in_bitstream (in_bitstream),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_byte     (out_byte),
        .out_last     (out_last),
        .out_error    (out_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Frame value as a byte list: a carry adds one to the preceding byte and ripples
    // through 0xFF bytes, but never past the oldest still-unreleased byte.
    function automatic bit model(input logic [8:0] w[$]);
        int pidx = 0;
        int i;
        bit err = 1'b0;
        mb.delete();
        for (int j = 0; j < w.size(); j++) begin
            if (w[j][8]) begin
                if (j == 0) begin
                    err = 1'b1;
                end else begin
                    i = j - 1;
                    while (mb[i] == 8'hFF && i != pidx) begin
                        mb[i] = 8'h00;
                        i--;
                    end
                    if (mb[i] == 8'hFF) begin
                        mb[i] = 8'h00;
                        err = 1'b1;
                    end else begin
                        mb[i] = mb[i] + 8'd1;
                    end
                end
            end
            mb.push_back(w[j][7:0]);
            for (int t = mb.size() - 1; t > pidx; t--) begin
                if (mb[t] != 8'hFF) begin
                    pidx = t;
                    break;
                end
            end
        end
        return err;
    endfunction

    task automatic push_model_bytes();
        for (int i = 0; i < mb.size(); i++)
            exp_q.push_back({(i == mb.size() - 1) ? 1'b1 : 1'b0, mb[i]});
    endtask

    task automatic send_beat(input int cnt, input logic [17:0] bits, input logic last);
        int guard = 0;
        @(negedge cp_clk);
        in_valid     = 1'b1;
        in_count     = 2'(cnt);
        in_bitstream = bits;
        in_last      = last;
        while (!in_ready && guard < 5000) begin
            @(negedge cp_clk);
            guard++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready 0, expected 1");
        end
        @(posedge cp_clk);
        #1;
        in_valid = 1'b0;
        n_beats++;
    endtask

    task automatic send_frame(input logic [8:0] w[$], input bit rnd);
        int          i = 0;
        int          n;
        logic        lst = 1'b0;
        logic [17:0] bits;
        while (i < w.size()) begin
            n = rnd ? int'($urandom_range(1, 2)) : 2;
            if (n > w.size() - i) n = w.size() - i;
            lst = (i + n == w.size()) && !(rnd && $urandom_range(0, 3) == 0);
            bits = '0;
            for (int j = 0; j < n; j++) bits[j*9 +: 9] = w[i+j];
            send_beat(n, bits, lst);
            i += n;
        end
        if (!lst) send_beat(0, '0, 1'b1);
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 4000) begin
            @(negedge cp_clk);
            guard++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge cp_clk);
    endtask

    task automatic do_reset();
        @(negedge cp_clk);
        cp_reset = 1'b1;
        repeat (2) @(negedge cp_clk);
        cp_reset = 1'b0;
    endtask

    // Monitor: chooses out_ready for the coming edge, then scores any transfer.
    initial begin : monitor
        logic       held;
        exp_t       held_v;
        logic       held_err;
        exp_t       e;
        held = 1'b0;
        forever begin
            @(negedge cp_clk);
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 9) >= 3);
            endcase
            if (cp_reset) begin
                held = 1'b0;
            end else begin
                if (held && out_valid)
                    check("hold_stable", 32'({out_error, out_last, out_byte}),
                          32'({held_err, held_v}));
                held     = out_valid && !out_ready;
                held_v   = {out_last, out_byte};
                held_err = out_error;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %0h last %0b, expected none",
                                 out_byte, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_byte", 32'(out_byte), 32'(e.data));
                        check("out_last", 32'(out_last), 32'(e.last));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [8:0] w[$];
        int         len;
        int         target;
        logic [7:0] l;
        logic       c;

        repeat (2) @(posedge cp_clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_byte", 32'(out_byte), 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        check("reset_out_error", 32'(out_error), 32'd0);
        @(negedge cp_clk);
        cp_reset = 1'b0;
        ready_mode = 1;

        // Plain bytes, single beat.
        exp_q.push_back({1'b0, 8'h12});
        exp_q.push_back({1'b1, 8'h34});
        w = '{9'h012, 9'h034};
        send_frame(w, 1'b0);
        drain();
        check("no_carry_error", 32'(out_error), 32'd0);

        // The byte after an FF run is held back until the flush.
        exp_q.push_back({1'b0, 8'h40});
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b1, 8'h55});
        send_beat(2, {9'h0FF, 9'h040}, 1'b0);
        send_beat(2, {9'h055, 9'h0FF}, 1'b0);
        repeat (20) @(negedge cp_clk);
        check("held_until_flush", 32'(exp_q.size()), 32'd1);
        send_beat(0, '0, 1'b1);
        drain();

        // Carry ripples through a run of FF bytes.
        exp_q.push_back({1'b0, 8'h41});
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b1, 8'h05});
        w = '{9'h040, 9'h0FF, 9'h0FF, 9'h105};
        send_frame(w, 1'b0);
        drain();

        // Carrying word that is itself all ones, then a later carry into it.
        w = '{9'h040, 9'h1FF, 9'h101};
        check("model_err_ones_word", 32'(model(w)), 32'd0);
        push_model_bytes();
        send_frame(w, 1'b0);
        drain();
        check("ones_word_error", 32'(out_error), 32'd0);

        // Random error-free frames under random backpressure.
        ready_mode = 2;
        target = n_beats + 10000;
        while (n_beats < target) begin
            do begin
                w.delete();
                len = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 8));
                for (int j = 0; j < len; j++) begin
                    l = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom());
                    c = (j > 0) && ($urandom_range(0, 3) == 0);
                    w.push_back({c, l});
                end
            end while (model(w));
            push_model_bytes();
            send_frame(w, 1'b1);
        end
        drain();
        check("random_error", 32'(out_error), 32'd0);

        // Carry into the first word of a frame has nowhere to go.
        do_reset();
        exp_q.push_back({1'b1, 8'hAB});
        send_beat(1, {9'h000, 9'h1AB}, 1'b1);
        drain();
        check("first_carry_error", 32'(out_error), 32'd1);

        // Run counter saturates on the 256th consecutive FF after a pending byte.
        do_reset();
        exp_q.push_back({1'b0, 8'h40});
        for (int i = 0; i < 255; i++) exp_q.push_back({(i == 254) ? 1'b1 : 1'b0, 8'hFF});
        send_beat(2, {9'h0FF, 9'h040}, 1'b0);
        for (int i = 0; i < 127; i++) send_beat(2, {9'h0FF, 9'h0FF}, 1'b0);
        send_beat(1, {9'h000, 9'h0FF}, 1'b1);
        drain();
        check("saturation_error", 32'(out_error), 32'd1);

        // Reset while stalled in the middle of emitting a run.
        do_reset();
        ready_mode = 0;
        send_beat(2, {9'h0FF, 9'h040}, 1'b0);
        send_beat(2, {9'h0FF, 9'h0FF}, 1'b0);
        send_beat(1, {9'h000, 9'h105}, 1'b0);
        repeat (6) @(negedge cp_clk);
        check("stalled_valid", 32'(out_valid), 32'd1);
        check("stalled_byte", 32'(out_byte), 32'h41);
        cp_reset = 1'b1;
        @(posedge cp_clk);
        #1;
        check("midrun_out_valid", 32'(out_valid), 32'd0);
        check("midrun_out_byte", 32'(out_byte), 32'd0);
        check("midrun_in_ready", 32'(in_ready), 32'd0);
        @(negedge cp_clk);
        cp_reset = 1'b0;
        ready_mode = 2;
        repeat (20) @(negedge cp_clk);
        exp_q.push_back({1'b0, 8'h12});
        exp_q.push_back({1'b1, 8'h34});
        w = '{9'h012, 9'h034};
        send_frame(w, 1'b0);
        drain();
        check("after_reset_error", 32'(out_error), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
